// File: rtl/aes_block_sequencer_pkg.sv
// Shared types and constants for the AES block sequencer.
package aes_seq_pkg;

    localparam int AES_BLK_W = 128;
    localparam int CNT_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_RUN       = 3'd3,
        ST_HOLD      = 3'd4
    } seq_state_e;

    // Completed-block counter step; wraps from all-ones to zero.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return c + 16'd1;
    endfunction

endpackage

// File: rtl/aes_block_sequencer_fifo.sv
// Synchronous plaintext FIFO with count-based full/empty flags.
module aes_seq_fifo
    import aes_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_push,
    input  logic [AES_BLK_W-1:0] i_data,
    input  logic                 i_pop,
    output logic [AES_BLK_W-1:0] o_data,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AES_BLK_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];

    // Pointer/count bookkeeping and storage write.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/aes_block_sequencer.sv
// Feeds queued plaintext blocks one at a time to an AES core and holds each
// ciphertext until the downstream consumer accepts it.
module aes_block_sequencer
    import aes_seq_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int START_TIMEOUT = 4
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic                 key_we_i,
    input  logic [AES_BLK_W-1:0] key_i,
    input  logic                 pt_valid_i,
    output logic                 pt_ready_o,
    input  logic [AES_BLK_W-1:0] pt_data_i,
    output logic                 load_o,
    output logic [AES_BLK_W-1:0] core_key_o,
    output logic [AES_BLK_W-1:0] core_data_o,
    input  logic                 busy_i,
    input  logic [AES_BLK_W-1:0] core_result_i,
    output logic                 ct_valid_o,
    input  logic                 ct_ready_i,
    output logic [AES_BLK_W-1:0] ct_data_o,
    output logic [CNT_W-1:0]     blk_count_o,
    output logic                 timeout_err_o
);

    localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(START_TIMEOUT - 1);

    seq_state_e           r_state;
    logic [AES_BLK_W-1:0] r_key;
    logic [TW-1:0]        r_wait_cnt;
    logic                 r_load;
    logic                 r_ct_valid;
    logic [AES_BLK_W-1:0] r_ct_data;
    logic [AES_BLK_W-1:0] r_core_data;
    logic [AES_BLK_W-1:0] r_core_key;
    logic [CNT_W-1:0]     r_blk_count;
    logic                 r_timeout_err;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_start;
    logic [AES_BLK_W-1:0] w_head;

    assign pt_ready_o = ~w_full & ~rst_i;
    assign w_push     = pt_valid_i & pt_ready_o;
    assign w_start    = (r_state == ST_IDLE) & ~w_empty & ~busy_i & ~r_ct_valid;

    aes_seq_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_rst   (rst_i),
        .i_push  (w_push),
        .i_data  (pt_data_i),
        .i_pop   (w_start),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Key register; the core only sees the snapshot taken at block start.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_key <= '0;
        end else if (key_we_i) begin
            r_key <= key_i;
        end
    end

    // Sequencer FSM with registered core and ciphertext outputs.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= '0;
            r_load        <= 1'b0;
            r_ct_valid    <= 1'b0;
            r_ct_data     <= '0;
            r_core_data   <= '0;
            r_core_key    <= '0;
            r_blk_count   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state     <= ST_LOAD;
                        r_load      <= 1'b1;
                        r_core_data <= w_head;
                        r_core_key  <= r_key;
                    end
                end
                ST_LOAD: begin
                    r_load     <= 1'b0;
                    r_wait_cnt <= '0;
                    r_state    <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (busy_i) begin
                        r_state <= ST_RUN;
                    end else if (r_wait_cnt == TO_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!busy_i) begin
                        r_ct_data   <= core_result_i;
                        r_ct_valid  <= 1'b1;
                        r_blk_count <= cnt_inc(r_blk_count);
                        r_state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (ct_ready_i) begin
                        r_ct_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_load     <= 1'b0;
                    r_ct_valid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign load_o        = r_load;
    assign core_key_o    = r_core_key;
    assign core_data_o   = r_core_data;
    assign ct_valid_o    = r_ct_valid;
    assign ct_data_o     = r_ct_data;
    assign blk_count_o   = r_blk_count;
    assign timeout_err_o = r_timeout_err;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Scoreboard bench for aes_block_sequencer with a behavioural AES core model.
module tb_aes_block_sequencer;

    localparam int DEPTH = 4;
    localparam int TO    = 4;
    localparam logic [127:0] MASK = 128'hA5A5_5A5A_C3C3_3C3C_0F1E_2D3C_4B5A_6978;
    localparam logic [127:0] KEY_F = 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         key_we_i;
    logic [127:0] key_i;
    logic         pt_valid_i;
    logic         pt_ready_o;
    logic [127:0] pt_data_i;
    logic         load_o;
    logic [127:0] core_key_o;
    logic [127:0] core_data_o;
    logic         busy_i;
    logic [127:0] core_result_i = 128'd0;
    logic         ct_valid_o;
    logic         ct_ready_i;
    logic [127:0] ct_data_o;
    logic [15:0]  blk_count_o;
    logic         timeout_err_o;

    logic core_busy = 1'b0;
    logic stall;
    bit   core_en;
    int   core_lat;
    int   busy_cnt = 0;
    bit   pending = 1'b0;
    bit   mon_en = 1'b0;

    assign busy_i = core_busy | stall;

    typedef struct {logic [127:0] data; logic [15:0] cnt;} ct_t;
    typedef struct {logic [127:0] data; logic [127:0] key;} ld_t;
    ct_t exp_ct[$];
    ld_t exp_ld[$];

    int checks = 0;
    int errors = 0;
    int loads  = 0;
    logic [127:0] tb_key;
    logic [15:0]  exp_cnt;

    always #5 clk = ~clk;

    aes_block_sequencer #(.FIFO_DEPTH(DEPTH), .START_TIMEOUT(TO)) dut (
        .clk(clk), .rst_i(rst_i), .key_we_i(key_we_i), .key_i(key_i),
        .pt_valid_i(pt_valid_i), .pt_ready_o(pt_ready_o), .pt_data_i(pt_data_i),
        .load_o(load_o), .core_key_o(core_key_o), .core_data_o(core_data_o),
        .busy_i(busy_i), .core_result_i(core_result_i),
        .ct_valid_o(ct_valid_o), .ct_ready_i(ct_ready_i), .ct_data_o(ct_data_o),
        .blk_count_o(blk_count_o), .timeout_err_o(timeout_err_o)
    );

    function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k);
        return {d[63:0], d[127:64]} ^ k ^ MASK;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Core model: starts one cycle after it sees load_o, busy for core_lat cycles.
    always @(negedge clk) begin
        if (pending) begin
            core_busy = 1'b1;
            busy_cnt  = core_lat;
            pending   = 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) core_busy = 1'b0;
        end else if (load_o && core_en && mon_en) begin
            pending       = 1'b1;
            core_result_i = core_fn(core_data_o, core_key_o);
        end
    end

    // Monitor: pops expectations on every load pulse and ciphertext handshake.
    always @(negedge clk) begin
        ld_t l;
        ct_t c;
        if (mon_en) begin
            if (load_o) begin
                loads++;
                if (exp_ld.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_load: got load_o=1 expected none");
                end else begin
                    l = exp_ld.pop_front();
                    chk("load_data", core_data_o, l.data);
                    chk("load_key", core_key_o, l.key);
                end
            end
            if (ct_valid_o && ct_ready_i) begin
                if (exp_ct.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ct: got ct %h expected none", ct_data_o);
                end else begin
                    c = exp_ct.pop_front();
                    chk("ct_data", ct_data_o, c.data);
                    chk("ct_blk_count", 128'(blk_count_o), 128'(c.cnt));
                end
            end
        end
    end

    task automatic push(input logic [127:0] d, input bit exp_out);
        int  n;
        bit  ok;
        ld_t l;
        ct_t c;
        n = 0; ok = 1'b0;
        pt_valid_i = 1'b1;
        pt_data_i  = d;
        while (!ok && n < 300) begin
            if (pt_ready_o) ok = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        pt_valid_i = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL push_accept: got no accept expected accept within 300 cycles");
        end else begin
            l.data = d; l.key = tb_key;
            exp_ld.push_back(l);
            if (exp_out) begin
                exp_cnt = exp_cnt + 16'd1;
                c.data = core_fn(d, tb_key); c.cnt = exp_cnt;
                exp_ct.push_back(c);
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_ct.size() != 0 || exp_ld.size() != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 128'(exp_ct.size() + exp_ld.size()), 128'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_busy();
        int n;
        n = 0;
        while (!busy_i && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chkb("busy_seen", busy_i, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int l0;
        bit seen;
        logic [127:0] v;
        logic [127:0] held;

        rst_i = 1'b1; key_we_i = 1'b0; key_i = 128'd0; pt_valid_i = 1'b0;
        pt_data_i = 128'd0; ct_ready_i = 1'b1; stall = 1'b0; core_en = 1'b1;
        core_lat = 10; tb_key = 128'd0; exp_cnt = 16'd0;

        // Reset state
        repeat (2) @(posedge clk); #1;
        chkb("ready_in_reset", pt_ready_o, 1'b0);
        chkb("rst_load", load_o, 1'b0);
        chkb("rst_ct_valid", ct_valid_o, 1'b0);
        chk("rst_ct_data", ct_data_o, 128'd0);
        chk("rst_blk_count", 128'(blk_count_o), 128'd0);
        chkb("rst_timeout", timeout_err_o, 1'b0);
        rst_i = 1'b0; mon_en = 1'b1;
        @(negedge clk);
        chkb("ready_after_reset", pt_ready_o, 1'b1);
        @(posedge clk); #1;

        // Single block, all-ones plaintext, key 0, core busy 10 cycles
        core_lat = 10;
        push({128{1'b1}}, 1'b1);
        n = 0;
        while (!ct_valid_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 128'(n), 128'd13);
        wait_drain();
        chk("blk_count_one", 128'(blk_count_o), 128'd1);
        chk("load_pulses_one", 128'(loads), 128'd1);

        // Five blocks back-to-back while the core appears busy
        core_lat = 2; stall = 1'b1; l0 = loads;
        for (int i = 0; i < 4; i++) begin
            v = {4{32'h1111_0000 + 32'(i)}};
            push(v, 1'b1);
        end
        chkb("ready_low_full", pt_ready_o, 1'b0);
        chk("no_load_while_stalled", 128'(loads), 128'(l0));
        fork
            push({4{32'h2222_0004}}, 1'b1);
            begin
                repeat (6) @(posedge clk);
                #1 stall = 1'b0;
            end
        join
        wait_drain();
        chk("blk_count_six", 128'(blk_count_o), 128'd6);

        // Downstream back-pressure for 20 cycles with a second block queued
        ct_ready_i = 1'b0; core_lat = 3;
        push(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1);
        push(128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 1'b1);
        n = 0;
        while (!ct_valid_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        held = ct_data_o;
        chk("held_result", held, core_fn(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'd0));
        l0 = loads;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chkb("hold_valid", ct_valid_o, 1'b1);
            chk("hold_data", ct_data_o, held);
            chk("hold_core_data", core_data_o, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        end
        chk("no_load_in_hold", 128'(loads), 128'(l0));
        ct_ready_i = 1'b1;
        @(posedge clk); #1;
        chkb("no_load_on_accept", load_o, 1'b0);
        chkb("ct_valid_cleared", ct_valid_o, 1'b0);
        @(posedge clk); #1;
        chkb("load_after_accept", load_o, 1'b1);
        wait_drain();
        chk("blk_count_eight", 128'(blk_count_o), 128'd8);

        // Core never starts: sticky timeout, next block still processed
        core_en = 1'b0;
        push(128'h7777_0000_7777_0000_7777_0000_7777_0000, 1'b0);
        n = 0;
        while (!timeout_err_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("timeout_cycles", 128'(n), 128'(2 + TO));
        @(posedge clk); #1;
        chkb("timeout_sticky", timeout_err_o, 1'b1);
        core_en = 1'b1; core_lat = 4;
        push(128'h8888_1111_8888_1111_8888_1111_8888_1111, 1'b1);
        wait_drain();
        chkb("timeout_still_set", timeout_err_o, 1'b1);
        chk("blk_count_nine", 128'(blk_count_o), 128'd9);

        // Key written mid-operation applies only to the following block
        core_lat = 8;
        push(128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 1'b1);
        wait_busy();
        @(posedge clk); #1;
        key_we_i = 1'b1; key_i = KEY_F;
        @(posedge clk); #1;
        key_we_i = 1'b0;
        chk("core_key_held", core_key_o, 128'd0);
        tb_key = KEY_F;
        push(128'h1357_9BDF_2468_ACE0_1357_9BDF_2468_ACE0, 1'b1);
        wait_drain();
        chk("core_key_new", core_key_o, KEY_F);

        // Reset while RUN abandons the block
        core_lat = 10;
        push(128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D, 1'b0);
        wait_busy();
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        chkb("mid_rst_load", load_o, 1'b0);
        chkb("mid_rst_ct_valid", ct_valid_o, 1'b0);
        chk("mid_rst_ct_data", ct_data_o, 128'd0);
        chk("mid_rst_core_data", core_data_o, 128'd0);
        chk("mid_rst_core_key", core_key_o, 128'd0);
        chk("mid_rst_blk_count", 128'(blk_count_o), 128'd0);
        chkb("mid_rst_timeout", timeout_err_o, 1'b0);
        chkb("mid_rst_ready", pt_ready_o, 1'b0);
        rst_i = 1'b0; tb_key = 128'd0; exp_cnt = 16'd0;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (ct_valid_o) seen = 1'b1;
        end
        chkb("no_ct_after_reset", seen, 1'b0);
        chkb("core_done", busy_i, 1'b0);

        // Counter wrap from 0xFFFF
        force dut.r_blk_count = 16'hFFFF;
        #1 release dut.r_blk_count;
        exp_cnt = 16'hFFFF; core_lat = 1;
        push(128'h0000_0000_0000_0000_0000_0000_0000_00A5, 1'b1);
        wait_drain();
        chk("blk_count_wrap", 128'(blk_count_o), 128'd0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_block_sequencer.md
AES_BLOCK_SEQUENCER -- requirements
Module: aes_block_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, power of two >= 2; plaintext FIFO entries.
REQ-002 Parameter START_TIMEOUT, default 4; max cycles from load_o to busy_i rising.
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 key_we_i  in  1  write key_i into key register.
REQ-006 key_i  in  128  AES key.
REQ-007 pt_valid_i  in  1  plaintext block offered.
REQ-008 pt_ready_o  out  1  FIFO not full.
REQ-009 pt_data_i  in  128  plaintext block.
REQ-010 load_o  out  1  one-cycle start pulse to AES core.
REQ-011 core_key_o  out  128  key to core.
REQ-012 core_data_o  out  128  plaintext to core.
REQ-013 busy_i  in  1  AES core busy.
REQ-014 core_result_i  in  128  AES core output.
REQ-015 ct_valid_o  out  1  ciphertext available.
REQ-016 ct_ready_i  in  1  downstream accepts ciphertext.
REQ-017 ct_data_o  out  128  ciphertext.
REQ-018 blk_count_o  out  16  completed blocks, wraps 0xFFFF->0.
REQ-019 timeout_err_o  out  1  sticky, core failed to start.

Function
REQ-020 Push on pt_valid_i && pt_ready_o; pop only in IDLE->LOAD; simultaneous push and pop when full SHALL NOT occur (pt_ready_o low when full); when empty, a push is not visible to pop until next cycle.
REQ-021 key_we_i writes key register in any state; core_key_o is a snapshot taken on IDLE->LOAD, so mid-operation writes apply to the next block only.
REQ-022 States IDLE, LOAD, WAIT_BUSY, RUN, HOLD.
REQ-023 IDLE->LOAD when FIFO non-empty, busy_i low and ct_valid_o low; pops head into core_data_o.
REQ-024 LOAD lasts exactly one cycle with load_o=1, then WAIT_BUSY; load_o is 0 in all other states.
REQ-025 WAIT_BUSY->RUN on busy_i=1; after START_TIMEOUT cycles without busy_i, set timeout_err_o, drop block, go IDLE.
REQ-026 RUN->HOLD on busy_i=0; same edge captures core_result_i into ct_data_o, sets ct_valid_o, increments blk_count_o.
REQ-027 HOLD: ct_valid_o/ct_data_o stable until ct_ready_i=1; on that cycle ct_valid_o clears and state returns IDLE; no new LOAD in the same cycle.
REQ-028 Minimum latency pt push to ct_valid_o = 3 + core busy cycles; one block in flight at a time.
REQ-029 core_data_o and core_key_o held stable from LOAD until HOLD exit.

Reset
REQ-030 rst_i=1 SHALL, at next posedge: FIFO empty, state IDLE, load_o=0, ct_valid_o=0, ct_data_o=0, core_data_o=0, core_key_o=0, key register=0, blk_count_o=0, timeout_err_o=0, pt_ready_o=0 during reset, 1 the first cycle after.
REQ-031 Reset mid-operation SHALL abandon the in-flight block; a later falling busy_i from the core SHALL NOT produce ct_valid_o.

Structure
REQ-032 Shared package aes_seq_pkg holds state enum, AES_BLK_W=128, CNT_W=16.
REQ-033 One sub-module, aes_seq_fifo (synchronous FIFO, FIFO_DEPTH x 128, count-based full/empty).
REQ-034 Sequencer FSM and output register reside in top module; no combinational path from busy_i to load_o.

Verification
REQ-035 Key 0, push 0xFFFF...FF, ct_ready_i=1, core model busy 10 cycles -> one load_o pulse, ct_data_o = core result, blk_count_o=1.
REQ-036 Push 5 blocks back-to-back, FIFO_DEPTH=4 -> pt_ready_o low after 4th accepted while IDLE stalled by busy, all 5 ciphertexts emitted in push order.
REQ-037 ct_ready_i held 0 for 20 cycles after result -> ct_valid_o/ct_data_o stable, no load_o until accepted.
REQ-038 Core model never raises busy -> timeout_err_o=1 after 4 cycles in WAIT_BUSY, next block still processed.
REQ-039 key_we_i with 0x0F..0F during RUN -> core_key_o unchanged until next LOAD, then 0x0F..0F.
REQ-040 rst_i asserted in RUN -> all outputs zero next cycle, no ct_valid_o when core busy drops; blk_count_o preset near 0xFFFF wraps to 0.
